// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one fixed-latency pipelined alu among N_REQ requesters.
// A round-robin arbiter grants at most one request per cycle, registers the
// chosen operation towards the alu, and carries the requester id alongside
// the op through a tag pipeline so every result comes back tagged.
module alu_arbiter #(
  parameter  int WIDTH   = 8,
  parameter  int N_REQ   = 4,
  parameter  int ALU_LAT = 2,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  input  logic                   drain,
  output logic [1:0]             alu_op,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic                   alu_in_valid,
  input  logic [WIDTH-1:0]       alu_out,
  input  logic                   alu_out_valid,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [IDW+1:0]         in_flight,
  output logic                   idle,
  output logic                   tag_err
);

  localparam logic [1:0] OP_NOP = 2'd0;

  // Round-robin pointer: the requester that has first claim next cycle.
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   ptr_next;

  // Arbitration result for the current cycle.
  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [N_REQ-1:0] grant_vec;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // Id of the op currently presented to the alu.
  logic [IDW-1:0]   issue_id;

  // Tag pipeline, one entry per alu stage; the last entry pairs with alu_out.
  logic             tag_v  [ALU_LAT];
  logic [IDW-1:0]   tag_id [ALU_LAT];
  logic             head_v;
  logic [IDW-1:0]   head_id;

  // Pick the first valid requester at or after ptr, then mux its operands.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    grant_any = 1'b0;
    grant_id  = '0;
    grant_vec = '0;
    ptr_next  = ptr;
    sel_op    = OP_NOP;
    sel_a     = '0;
    sel_b     = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IDW'(idx);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    // Drain and reset suppress the grant within the same cycle.
    if (drain || rst) grant_any = 1'b0;
    if (grant_any) begin
      grant_vec[grant_id] = 1'b1;
      ptr_next = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_vec[i]) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  assign req_ready = grant_vec;

  // Register the granted op towards the alu and advance the pointer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      ptr          <= '0;
      alu_in_valid <= 1'b0;
      alu_op       <= OP_NOP;
      alu_a        <= '0;
      alu_b        <= '0;
      issue_id     <= '0;
    end else begin
      alu_in_valid <= grant_any;
      if (grant_any) begin
        alu_op   <= sel_op;
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        issue_id <= grant_id;
        ptr      <= ptr_next;
      end
    end
  end

  // Shift {valid,id} alongside the alu so the head lines up with alu_out_valid.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the tag pipeline is a handful of control flops and is reset so
    // ops in flight at reset are forgotten; a wide data array would not be.
    if (rst) begin
      for (int k = 0; k < ALU_LAT; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= alu_in_valid;
      tag_id[0] <= issue_id;
      for (int k = 1; k < ALU_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign head_v  = tag_v[ALU_LAT-1];
  assign head_id = tag_id[ALU_LAT-1];

  // Register the tagged response; a disagreement between the tag head and
  // alu_out_valid means the alu and the arbiter lost sync, so flag it sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      tag_err   <= 1'b0;
    end else begin
      rsp_valid <= head_v && alu_out_valid;
      if (head_v && alu_out_valid) begin
        rsp_id   <= head_id;
        rsp_data <= alu_out;
      end
      if (head_v != alu_out_valid) tag_err <= 1'b1;
    end
  end

  // Count ops between handshake and presented response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({grant_any, rsp_valid})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  assign idle = (in_flight == '0) && !alu_in_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed stimulus for alu_arbiter with a
// behavioural 2-cycle alu, a round-robin reference model and a scoreboard.
`timescale 1ns/1ps
module tb_alu_arbiter;

  localparam int WIDTH   = 8;
  localparam int N       = 4;
  localparam int ALU_LAT = 2;
  localparam int IDW     = $clog2(N);
  localparam int RSP_LAT = ALU_LAT + 2;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [2*N-1:0]       req_op = '0;
  logic [WIDTH*N-1:0]   req_a = '0;
  logic [WIDTH*N-1:0]   req_b = '0;
  logic                 drain = 1'b0;
  logic [1:0]           alu_op;
  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic                 alu_in_valid;
  logic [WIDTH-1:0]     alu_out;
  logic                 alu_out_valid;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [WIDTH-1:0]     rsp_data;
  logic [IDW+1:0]       in_flight;
  logic                 idle;
  logic                 tag_err;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   mptr  = 0;
  bit   gate_all    = 1'b1;
  bit   force_ov    = 1'b0;
  bit   exp_tag_err = 1'b0;

  op_t  pq [N][$];
  exp_t sb [$];
  int   grant_log [$];

  alu_arbiter #(.WIDTH(WIDTH), .N_REQ(N), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .drain(drain),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_in_valid(alu_in_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .in_flight(in_flight), .idle(idle), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [WIDTH-1:0] ref_alu(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return '0;
    endcase
  endfunction

  // Behavioural alu: two register stages between in_valid and out_valid.
  logic             s0_v, s1_v;
  logic [WIDTH-1:0] s0_d, s1_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v <= 1'b0; s1_v <= 1'b0; s0_d <= '0; s1_d <= '0;
    end else begin
      s0_v <= alu_in_valid;
      s0_d <= ref_alu(alu_op, alu_a, alu_b);
      s1_v <= s0_v;
      s1_d <= s0_d;
    end
  end
  assign alu_out_valid = s1_v | force_ov;
  assign alu_out       = s1_d;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (pq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.op = 2'($urandom_range(0, 2));
    o.a  = WIDTH'($urandom);
    o.b  = WIDTH'($urandom);
    return o;
  endfunction

  // Reference arbiter: first valid requester at/after mptr; expected
  // responses are queued with the cycle they must appear in.
  always @(negedge clk) begin
    int           g;
    int           idx;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    if (rst) begin
      mptr = 0;
    end else begin
      g = -1;
      exp_rdy = '0;
      if (!drain) begin
        for (int k = 0; k < N; k++) begin
          idx = (mptr + k) % N;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy = N'(1) << g;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);
      if (g >= 0) begin
        if (pq[g].size() > 0) begin
          e.id   = g;
          e.data = ref_alu(pq[g][0].op, pq[g][0].a, pq[g][0].b);
          e.due  = cyc + RSP_LAT;
          sb.push_back(e);
          void'(pq[g].pop_front());
        end
        mptr = (g + 1) % N;
      end
    end
  end

  // Scoreboard monitor: pops and compares whenever a response is presented.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_cycle", 32'(cyc), 32'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        check("rsp_missing_at_due", 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
      check("tag_err", 32'(tag_err), 32'(exp_tag_err));
    end
  end

  // Advance one cycle and present the head of each requester queue.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0) begin
        req_op[2*i +: 2]         = pq[i][0].op;
        req_a[WIDTH*i +: WIDTH]  = pq[i][0].a;
        req_b[WIDTH*i +: WIDTH]  = pq[i][0].b;
        req_valid[i] = gate_all || ($urandom_range(0, 3) != 0);
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic run_until_empty(input string name);
    for (int n = 0; n < 300; n++) begin
      tick();
      @(negedge clk);
      #1;
      if (all_empty()) break;
    end
    tick();
    check({name, "_all_granted"}, 32'(all_empty()), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && idle && in_flight == '0) break;
    end
    check({name, "_idle"}, 32'(idle), 32'd1);
    check({name, "_in_flight"}, 32'(in_flight), 32'd0);
    check({name, "_pending_rsp"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_valid = '0;
    sb.delete();
    for (int i = 0; i < N; i++) pq[i].delete();
    exp_tag_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_req_ready"}, 32'(req_ready), 32'd0);
    check({name, "_alu_in_valid"}, 32'(alu_in_valid), 32'd0);
    check({name, "_alu_op"}, 32'(alu_op), 32'd0);
    check({name, "_alu_ab"}, {16'd0, alu_a, alu_b}, 32'd0);
    check({name, "_rsp"}, {23'd0, rsp_valid, rsp_id, rsp_data}, 32'd0);
    check({name, "_in_flight"}, 32'(in_flight), 32'd0);
    check({name, "_idle"}, 32'(idle), 32'd1);
    check({name, "_tag_err"}, 32'(tag_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_seq [$];
    op_t o;

    // Reset state.
    #2 rst = 1'b1;
    #1 check_reset_values("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single add from requester 0: response exactly RSP_LAT cycles later.
    o.op = 2'd1; o.a = 8'd5; o.b = 8'd3;
    pq[0].push_back(o);
    tick();
    @(negedge clk);
    tick();
    @(negedge clk);
    check("single_alu_in_valid", 32'(alu_in_valid), 32'd1);
    check("single_alu_op", 32'(alu_op), 32'd1);
    check("single_alu_ab", {16'd0, alu_a, alu_b}, 32'h0503);
    check("single_in_flight", 32'(in_flight), 32'd1);
    check("single_idle", 32'(idle), 32'd0);
    wait_idle("single");

    // All four requesters, two subs each: strict rotation from pointer 0.
    reset_pulse();
    grant_log.delete();
    o.op = 2'd2; o.a = 8'd2; o.b = 8'd5;
    for (int i = 0; i < N; i++) begin
      pq[i].push_back(o);
      pq[i].push_back(o);
    end
    run_until_empty("rotate");
    wait_idle("rotate");
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
    check("rotate_grant_count", 32'(grant_log.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++)
      check("rotate_grant_order", 32'(grant_log[i]), 32'(exp_seq[i]));

    // Only requester 2 with the pointer at 3: grant wraps back to 2,
    // then requesters 3 and 0 together prove the pointer sits at 3.
    grant_log.delete();
    for (int i = 0; i < 3; i++) pq[2].push_back(rand_op());
    run_until_empty("wrap2");
    pq[0].push_back(rand_op());
    pq[3].push_back(rand_op());
    run_until_empty("wrap30");
    wait_idle("wrap");
    exp_seq = '{2, 2, 2, 3, 0};
    check("wrap_grant_count", 32'(grant_log.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < grant_log.size(); i++)
      check("wrap_grant_order", 32'(grant_log[i]), 32'(exp_seq[i]));

    // Drain: an op granted just before drain still returns; req1 waits.
    pq[0].push_back(rand_op());
    tick();
    @(negedge clk);
    pq[1].push_back(rand_op());
    tick();
    drain = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    check("drain_req_ready", 32'(req_ready), 32'd0);
    check("drain_idle", 32'(idle), 32'd1);
    check("drain_in_flight", 32'(in_flight), 32'd0);
    check("drain_held_req", 32'(pq[1].size()), 32'd1);
    tick();
    drain = 1'b0;
    run_until_empty("undrain");
    wait_idle("undrain");

    // Randomized traffic with withdrawn requests and drain toggling.
    gate_all = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      drain = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0 && pq[i].size() < 3) pq[i].push_back(rand_op());
    end
    drain = 1'b0;
    gate_all = 1'b1;
    run_until_empty("random");
    wait_idle("random");

    // Reset with three ops in flight: everything drops, nothing returns.
    for (int i = 0; i < 3; i++) pq[i].push_back(rand_op());
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
    end
    tick();
    check("midrst_in_flight_before", 32'(in_flight), 32'd3);
    #2;
    rst = 1'b1;
    sb.delete();
    #1 check_reset_values("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    check("midrst_idle_after", 32'(idle), 32'd1);

    // Spurious alu_out_valid with an empty tag pipeline.
    tick();
    force_ov = 1'b1;
    tick();
    force_ov = 1'b0;
    exp_tag_err = 1'b1;
    @(negedge clk);
    check("tag_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (5) tick();
    @(negedge clk);
    check("tag_err_held", 32'(tag_err), 32'd1);
    reset_pulse();
    #1 check("tag_err_cleared", 32'(tag_err), 32'd0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
